icache_refill_ctrl: RTL and testbench

Sequences AHB-Lite read bursts that refill I-cache lines, arbitrating between a demand-miss requester and a prefetch requester. It sits between the cache tag/data arrays and the AHB master port. It issues one wrapping burst per request, critical word first, and streams returned words into the data array with a per-word strobe and a line-complete pulse.

---
 rtl/ahb_pkg.sv | 27 ++
 rtl/icache_refill_ctrl_arb.sv | 48 ++++
 rtl/icache_refill_ctrl.sv | 140 ++++++++++++++
 tb/tb_icache_refill_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// AHB-Lite encodings shared by the I-cache refill path.
// Also carries the refill FSM state type.
package ahb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } htrans_t;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;
    localparam logic [2:0] HBURST_WRAP4  = 3'b010;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;
    localparam logic [2:0] HBURST_WRAP8  = 3'b100;

    localparam logic [2:0] HSIZE_WORD = 3'b010;

    typedef enum logic [1:0] {
        S_IDLE,
        S_NSEQ,
        S_SEQ,
        S_LAST
    } fill_state_t;

endpackage

// File: rtl/icache_refill_ctrl_arb.sv
// Fixed-priority demand/prefetch arbiter.
// Latches the winning word address and source, and pulses its ack.
module refill_arb
    import ahb_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              en,
    input  logic              dem_req,
    input  logic [ADDR_W-1:0] dem_addr,
    input  logic              pf_req,
    input  logic [ADDR_W-1:0] pf_addr,
    output logic              grant,
    output logic [ADDR_W-3:0] grant_word,
    output logic [ADDR_W-3:0] word,
    output logic              src,
    output logic              dem_ack,
    output logic              pf_ack
);

    logic unused_lsbs;

    assign unused_lsbs = ^{dem_addr[1:0], pf_addr[1:0]};
    assign grant       = en & (dem_req | pf_req);
    assign grant_word  = dem_req ? dem_addr[ADDR_W-1:2]
                                 : pf_addr[ADDR_W-1:2];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            word    <= '0;
            src     <= 1'b0;
            dem_ack <= 1'b0;
            pf_ack  <= 1'b0;
        end else begin
            dem_ack <= 1'b0;
            pf_ack  <= 1'b0;
            if (grant) begin
                word    <= grant_word;
                src     <= ~dem_req;
                dem_ack <= dem_req;
                pf_ack  <= ~dem_req;
            end
        end
    end

endmodule

// File: rtl/icache_refill_ctrl.sv
// I-cache line refill sequencer: one critical-word-first AHB
// wrapping burst per accepted request, words streamed to the array.
module icache_refill_ctrl
    import ahb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LINE_WORDS = 4
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          dem_req,
    input  logic [ADDR_W-1:0]             dem_addr,
    output logic                          dem_ack,
    input  logic                          pf_req,
    input  logic [ADDR_W-1:0]             pf_addr,
    output logic                          pf_ack,
    output logic [ADDR_W-1:0]             haddr,
    output logic [1:0]                    htrans,
    output logic [2:0]                    hburst,
    output logic                          hwrite,
    input  logic [DATA_W-1:0]             hrdata,
    input  logic                          hready,
    output logic                          fill_valid,
    output logic [$clog2(LINE_WORDS)-1:0] fill_idx,
    output logic [DATA_W-1:0]             fill_data,
    output logic                          fill_src,
    output logic                          fill_done,
    output logic                          busy
);

    localparam int IW = $clog2(LINE_WORDS);
    localparam int WW = ADDR_W - 2;
    localparam logic [IW-1:0] LAST_CNT = IW'(LINE_WORDS - 1);

    fill_state_t      state;
    logic [IW-1:0]    cnt;
    logic [IW-1:0]    dph_idx;
    logic             pend;
    logic             grant;
    logic [WW-1:0]    grant_word;
    logic [WW-1:0]    word;
    logic             src;
    logic [IW-1:0]    start_idx;
    logic [IW-1:0]    cur_idx;
    logic [IW-1:0]    nxt_idx;
    logic [WW-IW-1:0] base;

    assign start_idx = word[IW-1:0];
    assign base      = word[WW-1:IW];
    assign cur_idx   = start_idx + cnt;
    assign nxt_idx   = cur_idx + IW'(1);
    assign hburst    = (LINE_WORDS == 8) ? HBURST_WRAP8 : HBURST_WRAP4;
    assign hwrite    = 1'b0;

    refill_arb #(.ADDR_W(ADDR_W)) u_arb (
        .clk        (clk),
        .rstn       (rstn),
        .en         (state == S_IDLE),
        .dem_req    (dem_req),
        .dem_addr   (dem_addr),
        .pf_req     (pf_req),
        .pf_addr    (pf_addr),
        .grant      (grant),
        .grant_word (grant_word),
        .word       (word),
        .src        (src),
        .dem_ack    (dem_ack),
        .pf_ack     (pf_ack)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= S_IDLE;
            cnt        <= '0;
            dph_idx    <= '0;
            pend       <= 1'b0;
            haddr      <= '0;
            htrans     <= IDLE;
            fill_valid <= 1'b0;
            fill_idx   <= '0;
            fill_data  <= '0;
            fill_src   <= 1'b0;
            fill_done  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            fill_valid <= 1'b0;
            fill_done  <= 1'b0;
            // Data phase of the previously accepted address beat.
            if (pend && hready) begin
                fill_valid <= 1'b1;
                fill_data  <= hrdata;
                fill_idx   <= dph_idx;
                fill_src   <= src;
                fill_done  <= (state == S_LAST);
            end
            unique case (state)
                S_IDLE: begin
                    busy <= grant;
                    if (grant) begin
                        state  <= S_NSEQ;
                        cnt    <= '0;
                        haddr  <= {grant_word, 2'b00};
                        htrans <= NONSEQ;
                    end
                end
                S_NSEQ: begin
                    if (hready) begin
                        pend    <= 1'b1;
                        dph_idx <= start_idx;
                        cnt     <= IW'(1);
                        state   <= S_SEQ;
                        htrans  <= SEQ;
                        haddr   <= {base, nxt_idx, 2'b00};
                    end
                end
                S_SEQ: begin
                    if (hready) begin
                        dph_idx <= cur_idx;
                        if (cnt == LAST_CNT) begin
                            state  <= S_LAST;
                            htrans <= IDLE;
                        end else begin
                            cnt   <= cnt + IW'(1);
                            haddr <= {base, nxt_idx, 2'b00};
                        end
                    end
                end
                S_LAST: begin
                    if (hready) begin
                        pend  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed bench for icache_refill_ctrl (4-word and 8-word lines).
// Slave returns {16'hDA7A, addr[15:0]}, garbage while hready is low.
module tb_icache_refill_ctrl;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        hready = 1'b1;
    logic [31:0] hrdata;

    logic        dem_req = 1'b0, pf_req = 1'b0;
    logic [31:0] dem_addr = '0, pf_addr = '0;
    logic        dem_ack, pf_ack, hwrite, fill_valid, fill_src;
    logic        fill_done, busy;
    logic [31:0] haddr, fill_data;
    logic [1:0]  htrans, fill_idx;
    logic [2:0]  hburst;

    logic        dem_req8 = 1'b0, pf_req8 = 1'b0;
    logic [31:0] dem_addr8 = '0, pf_addr8 = '0;
    logic        dem_ack8, pf_ack8, hwrite8, fill_valid8, fill_src8;
    logic        fill_done8, busy8;
    logic [31:0] haddr8, fill_data8;
    logic [1:0]  htrans8;
    logic [2:0]  fill_idx8, hburst8;

    logic [31:0] rec = '0;
    int          n_cmp = 0;
    int          n_err = 0;

    int          ht3[1:8] = '{2, 3, 3, 3, 3, 3, 0, 0};
    logic [31:0] ha3[1:8] = '{32'h3004, 32'h3008, 32'h300C, 32'h300C,
                              32'h300C, 32'h3000, 32'h3000, 32'h3000};
    int          hr3[1:8] = '{1, 1, 0, 0, 1, 1, 1, 1};
    int          fv3[1:8] = '{0, 0, 1, 0, 0, 1, 1, 1};
    int          fi3[1:8] = '{0, 0, 1, 0, 0, 2, 3, 0};
    logic [31:0] fd3[1:8] = '{0, 0, 32'hDA7A3004, 0, 0, 32'hDA7A3008,
                              32'hDA7A300C, 32'hDA7A3000};
    int          idx8[8] = '{5, 6, 7, 0, 1, 2, 3, 4};
    logic [31:0] ad8[8]  = '{32'h14, 32'h18, 32'h1C, 32'h00,
                             32'h04, 32'h08, 32'h0C, 32'h10};

    always #5 clk = ~clk;

    always @(posedge clk)
        if (hready && (htrans[1] || htrans8[1]))
            rec <= htrans[1] ? haddr : haddr8;

    assign hrdata = hready ? (32'hDA7A_0000 | (rec & 32'hFFFF))
                           : 32'hBAD0_BAD0;

    icache_refill_ctrl #(.LINE_WORDS(4)) u_dut (
        .clk(clk), .rstn(rstn),
        .dem_req(dem_req), .dem_addr(dem_addr), .dem_ack(dem_ack),
        .pf_req(pf_req), .pf_addr(pf_addr), .pf_ack(pf_ack),
        .haddr(haddr), .htrans(htrans), .hburst(hburst),
        .hwrite(hwrite), .hrdata(hrdata), .hready(hready),
        .fill_valid(fill_valid), .fill_idx(fill_idx),
        .fill_data(fill_data), .fill_src(fill_src),
        .fill_done(fill_done), .busy(busy)
    );

    icache_refill_ctrl #(.LINE_WORDS(8)) u_dut8 (
        .clk(clk), .rstn(rstn),
        .dem_req(dem_req8), .dem_addr(dem_addr8), .dem_ack(dem_ack8),
        .pf_req(pf_req8), .pf_addr(pf_addr8), .pf_ack(pf_ack8),
        .haddr(haddr8), .htrans(htrans8), .hburst(hburst8),
        .hwrite(hwrite8), .hrdata(hrdata), .hready(hready),
        .fill_valid(fill_valid8), .fill_idx(fill_idx8),
        .fill_data(fill_data8), .fill_src(fill_src8),
        .fill_done(fill_done8), .busy(busy8)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] wadr(input logic [31:0] a,
                                         input int k);
        return (a & 32'hFFFF_FFF0) | 32'(((int'(a[3:2]) + k) & 3) << 2);
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_fv"}, 32'(fill_valid), 32'd0);
        check({tag, "_htrans"}, 32'(htrans), 32'd0);
    endtask

    // Cycles 1..6 of a 4-word burst with hready high; the request
    // must already be driven before the call.
    task automatic burst(input logic [31:0] a, input logic pf,
                         input int raise_c, input logic [31:0] raise_a);
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (c == 1) begin
                if (pf) pf_req = 1'b0;
                else dem_req = 1'b0;
            end
            if (c == raise_c) begin
                dem_req  = 1'b1;
                dem_addr = raise_a;
            end
            check("dem_ack", 32'(dem_ack), 32'(c == 1 && !pf));
            check("pf_ack", 32'(pf_ack), 32'(c == 1 && pf));
            check("htrans", 32'(htrans),
                  (c == 1) ? 32'd2 : (c <= 4) ? 32'd3 : 32'd0);
            if (c <= 4)
                check("haddr", haddr, wadr(a, c - 1));
            check("fill_valid", 32'(fill_valid), 32'(c >= 3));
            if (c >= 3) begin
                check("fill_idx", 32'(fill_idx),
                      32'((int'(a[3:2]) + c - 3) & 3));
                check("fill_data", fill_data,
                      32'hDA7A_0000 | (wadr(a, c - 3) & 32'hFFFF));
                check("fill_src", 32'(fill_src), 32'(pf));
            end
            check("fill_done", 32'(fill_done), 32'(c == 6));
            check("busy", 32'(busy), 32'd1);
        end
    endtask

    initial begin
        #1;
        check("rst_htrans", 32'(htrans), 32'd0);
        check("rst_haddr", haddr, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_fv", 32'(fill_valid), 32'd0);
        check("rst_fdone", 32'(fill_done), 32'd0);
        check("rst_ack", 32'({dem_ack, pf_ack}), 32'd0);
        check("hwrite", 32'(hwrite), 32'd0);
        check("hburst4", 32'(hburst), 32'h2);
        check("hburst8", 32'(hburst8), 32'h4);
        tick();
        tick();
        rstn = 1'b1;
        tick();

        // Demand miss, critical word 2.
        dem_addr = 32'h0000_1038;
        dem_req  = 1'b1;
        burst(32'h0000_1038, 1'b0, 0, 0);
        tick();
        check_idle("t1");

        // Simultaneous demand and prefetch: demand wins.
        dem_addr = 32'h0000_1100;
        pf_addr  = 32'h0000_4008;
        dem_req  = 1'b1;
        pf_req   = 1'b1;
        burst(32'h0000_1100, 1'b0, 0, 0);
        burst(32'h0000_4008, 1'b1, 0, 0);
        tick();
        check_idle("t2");

        // Two wait states during the second SEQ beat.
        dem_addr = 32'h0000_3004;
        dem_req  = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (c == 1) dem_req = 1'b0;
            hready = hr3[c][0];
            check("ws_htrans", 32'(htrans), 32'(ht3[c]));
            if (c <= 6) check("ws_haddr", haddr, ha3[c]);
            check("ws_fv", 32'(fill_valid), 32'(fv3[c]));
            if (fv3[c] != 0) begin
                check("ws_fidx", 32'(fill_idx), 32'(fi3[c]));
                check("ws_fdata", fill_data, fd3[c]);
            end
            check("ws_fdone", 32'(fill_done), 32'(c == 8));
        end
        tick();
        check_idle("t3");

        // Demand raised mid-prefetch waits for the prefetch to end.
        pf_addr = 32'h0000_2000;
        pf_req  = 1'b1;
        burst(32'h0000_2000, 1'b1, 3, 32'h0000_6014);
        burst(32'h0000_6014, 1'b0, 0, 0);
        tick();
        check_idle("t4");

        // Reset mid-burst.
        dem_addr = 32'h0000_7008;
        dem_req  = 1'b1;
        tick();
        dem_req = 1'b0;
        tick();
        tick();
        rstn = 1'b0;
        #1;
        check("mr_htrans", 32'(htrans), 32'd0);
        check("mr_busy", 32'(busy), 32'd0);
        check("mr_fv", 32'(fill_valid), 32'd0);
        tick();
        rstn = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            check("mr_fdone", 32'(fill_done), 32'd0);
            check("mr_htrans2", 32'(htrans), 32'd0);
        end
        dem_addr = 32'h0000_500C;
        dem_req  = 1'b1;
        burst(32'h0000_500C, 1'b0, 0, 0);
        tick();
        check_idle("t5");

        // 8-word line, critical word 5.
        dem_addr8 = 32'h0000_0014;
        dem_req8  = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (c == 1) dem_req8 = 1'b0;
            check("w8_ack", 32'(dem_ack8), 32'(c == 1));
            if (c == 1) check("w8_nseq", 32'(htrans8), 32'd2);
            if (c == 9) check("w8_last", 32'(htrans8), 32'd0);
            check("w8_fv", 32'(fill_valid8), 32'(c >= 3));
            if (c >= 3) begin
                check("w8_fidx", 32'(fill_idx8), 32'(idx8[c - 3]));
                check("w8_fdata", fill_data8,
                      32'hDA7A_0000 | ad8[c - 3]);
            end
            check("w8_fdone", 32'(fill_done8), 32'(c == 10));
        end
        tick();
        check("w8_busy", 32'(busy8), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
